// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared FSM encoding, generator defaults and widths for the encoder/decoder pair.
package viterbi_pkg;
    typedef enum logic [1:0] {IDLE, ENC, DONE} state_t;
    localparam int DATA_W_DEF = 8;
    localparam int CW_W_DEF = 2 * DATA_W_DEF;
    localparam int TRELLIS_W = 2;
    localparam logic [2:0] G0_DEF = 3'b111;
    localparam logic [2:0] G1_DEF = 3'b101;
endpackage

// File: rtl/conv_enc_bit.sv
// conv_enc_bit: one trellis step; code pair {c0,c1} and next state from {u,s1,s0}.
module conv_enc_bit
    import viterbi_pkg::*;
(
    input  logic                 u,
    input  logic                 s1,
    input  logic                 s0,
    input  logic [2:0]           g0,
    input  logic [2:0]           g1,
    output logic [1:0]           code,
    output logic [TRELLIS_W-1:0] next_state
);
    logic [2:0] reg_bits;
    assign reg_bits   = {u, s1, s0};
    assign code       = {^(reg_bits & g0), ^(reg_bits & g1)};
    assign next_state = {u, s1};
endmodule

// File: rtl/conv_encoder.sv
// conv_encoder: rate-1/2 K=3 serial convolutional encoder, MSB first.
// CONV_ENC_CONT_STATE_EN keeps the trellis state across frames instead of clearing it.
module conv_encoder
    import viterbi_pkg::*;
#(
    parameter int         DATA_W = DATA_W_DEF,
    parameter logic [2:0] G0     = G0_DEF,
    parameter logic [2:0] G1     = G1_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [DATA_W-1:0]   data,
    output logic [2*DATA_W-1:0] data_out,
    output logic                done_flag,
    output logic                busy
);
    localparam int CW_W  = 2 * DATA_W;
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t                state, state_next;
    logic [DATA_W-1:0]     sreg;
    logic [CNT_W-1:0]      cnt;
    logic [CW_W-1:0]       cw, cw_next;
    logic [TRELLIS_W-1:0]  st, st_next;
    logic [1:0]            code;
    logic                  accept, last, busy_d, done_d;

    conv_enc_bit u_bit (
        .u          (sreg[DATA_W-1]),
        .s1         (st[1]),
        .s0         (st[0]),
        .g0         (G0),
        .g1         (G1),
        .code       (code),
        .next_state (st_next)
    );

    assign cw_next = {cw[CW_W-3:0], code};
    assign accept  = (state != ENC) && en;
    assign last    = (state == ENC) && (cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_next;

    always_comb begin
        state_next = state;
        if (accept)         state_next = ENC;
        else if (last)      state_next = DONE;
        else if (state == DONE) state_next = IDLE;
    end

    always_comb begin
        busy_d = (state_next == ENC);
        done_d = (state_next == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= 1'b0;
            done_flag <= 1'b0;
            data_out  <= '0;
            sreg      <= '0;
            cnt       <= '0;
            cw        <= '0;
            st        <= '0;
        end else begin
            busy      <= busy_d;
            done_flag <= done_d;
            if (accept) begin
                sreg <= data;
                cnt  <= '0;
                cw   <= '0;
`ifdef CONV_ENC_CONT_STATE_EN
                st   <= st;
`else
                st   <= '0;
`endif
            end else if (state == ENC) begin
                sreg <= sreg << 1;
                cnt  <= cnt + CNT_W'(1);
                cw   <= cw_next;
                st   <= st_next;
                if (last) data_out <= cw_next;
            end
        end
    end
endmodule

// File: doc/conv_encoder.md
Name: conv_encoder

Overview:
- Rate-1/2, constraint-length-3 convolutional encoder. It is the transmit-side counterpart of viterbi_decoder.
- Accepts one DATA_W-bit frame and encodes it serially, one bit per cycle, MSB first.
- Produces a 2*DATA_W-bit codeword laid out exactly as viterbi_decoder's data input expects.
- Sits ahead of the channel/decoder; with defaults its 16-bit data_out feeds the decoder's 16-bit data port directly.

Parameters:
- DATA_W, 8, information bits per frame.
- G0, 3'b111, generator for the upper code bit (octal 7), ordered {u, s1, s0}.
- G1, 3'b101, generator for the lower code bit (octal 5), ordered {u, s1, s0}.

Ports:
- clk  input  1  system clock; all flops rising-edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  frame start request; sampled in IDLE or DONE.
- data  input  DATA_W  information frame; captured on the accepting edge.
- data_out  output  2*DATA_W  registered codeword of the last completed frame.
- done_flag  output  1  one-cycle pulse; data_out is valid and updated.
- busy  output  1  high while in ENC.

Behaviour:
- Reset (asynchronous, active-high rst): FSM=IDLE, data_out=0, done_flag=0, busy=0, encoder state {s1,s0}=2'b00, bit counter=0, working shift register=0.
- FSM states: IDLE, ENC, DONE. All outputs are registered.
- IDLE, en=1 at an edge: capture data into the shift register, clear counter and the {s1,s0} state, go to ENC. en=0: stay in IDLE.
- ENC, each edge:
  - u = shift-register MSB.
  - c0 = XOR of ({u,s1,s0} & G0); c1 = XOR of ({u,s1,s0} & G1).
  - Shift {c0,c1} into the working codeword register, MSB side first.
  - Update s0<=s1, s1<=u; shift the data register left; counter++.
  - Bit data[DATA_W-1] yields data_out[2*DATA_W-1:2*DATA_W-2], with c0 in the upper position.
- ENC, edge where counter == DATA_W-1: final pair encoded; working codeword copied to data_out; go to DONE.
- en asserted during ENC is ignored (no queueing). Captured data is stable regardless of later input changes.
- DONE lasts exactly one cycle with done_flag=1.
  - en=1: accept a new frame immediately, same as IDLE, which allows back-to-back frames.
  - en=0: go to IDLE.
- Latency: accepting edge E → done_flag high in the cycle after edge E+DATA_W. Frame period is DATA_W+1 cycles when en is held high.
- data_out holds its value until the next frame completes. done_flag never holds high for two consecutive cycles.
- rst asserted mid-frame: immediate return to reset values; the partial codeword is discarded, done_flag is not asserted, and no data_out update occurs.
- Frame start always from state 00; this matches the decoder's traceback origin.

Optional Feature:
- Macro CONV_ENC_CONT_STATE_EN.
- Defined: {s1,s0} is NOT cleared at frame acceptance; the encoder state carries across frames as one continuous stream. Reset still clears it.
- Undefined (default): state is cleared to 00 at every frame acceptance.

Decomposition:
- Shared package viterbi_pkg holds:
  - FSM state encoding (IDLE/ENC/DONE).
  - Generator constants G0/G1 defaults.
  - DATA_W default and a CW_W = 2*DATA_W constant.
  - Trellis state width (2); also usable by ham_d/add_comp.
- One sub-module: conv_enc_bit, purely combinational. Inputs: u, s1, s0, G0, G1. Outputs: {c0,c1}, next state.

Test Plan:
- Reset then en with data=8'h00 → done_flag one cycle after edge E+8; data_out=16'h0000; busy high for exactly 8 cycles.
- data=8'h80 → data_out=16'hEC00 (pairs 11,10,11,00...). Impulse response equals G0/G1.
- data=8'hFF → data_out=16'hDAAA.
- Back-to-back 8'hFF then 8'h00, en held high:
  - First done_flag at E+9, second at E+18.
  - Default build: second data_out=16'h0000.
  - With CONV_ENC_CONT_STATE_EN: second data_out=16'h7000.
- en pulsed again during ENC; rst pulsed at encode cycle 4 → extra en ignored; rst clears all outputs to 0, no done_flag is asserted, and the next frame encodes normally.
- Loopback: feed data_out to viterbi_decoder for 20 random bytes → decoded data_out equals the original byte each time.
